// File: rtl/ps2_mouse_packet_if.sv
// Byte stream from the PS/2 serial receiver: a ready level plus the byte it qualifies.
interface ps2_mouse_packet_if;
  logic       byte_ready;
  logic [7:0] byte_data;

  modport master (output byte_ready, output byte_data);
  modport slave  (input  byte_ready, input  byte_data);
endinterface

// File: rtl/ps2_mouse_packet.sv
// Assembles 3-byte PS/2 mouse packets, decodes movement/buttons and tracks a
// clamped cursor position inside an X_MAX x Y_MAX screen.
module ps2_mouse_packet #(
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479,
  parameter int X_INIT         = 320,
  parameter int Y_INIT         = 240
) (
  input  logic              clk,
  input  logic              rst,
  ps2_mouse_packet_if.slave rx,
  output logic              pkt_valid,
  output logic [8:0]        dx,
  output logic [8:0]        dy,
  output logic              btn_left,
  output logic              btn_right,
  output logic              btn_middle,
  output logic              x_ovf,
  output logic              y_ovf,
  output logic [9:0]        cur_x,
  output logic [8:0]        cur_y,
  output logic              click,
  output logic              sync_err,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {B0 = 2'd0, B1 = 2'd1, B2 = 2'd2} state_t;

  localparam int                TW     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0]     T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic signed [11:0] XMAX12 = 12'(X_MAX);
  localparam logic signed [11:0] YMAX12 = 12'(Y_MAX);

  state_t        cur_state, next_state;
  logic          rdy_q;
  logic [TW-1:0] tcnt;
  logic [3:0]    b0_hi;
  logic [2:0]    b0_lo;
  logic [7:0]    b1;
  logic          prev_left;

  logic accept, tmo_hit;
  logic store_b0, store_b1, decode, reject, timeout;

  logic [8:0]        dx_new, dy_new;
  logic signed [11:0] nx, ny;
  logic [9:0]        nx_clamp;
  logic [8:0]        ny_clamp;

  assign accept  = rx.byte_ready & ~rdy_q;
  assign tmo_hit = (tcnt == T_LAST);
  assign state   = cur_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= B0;
    else     cur_state <= next_state;
  end

  // A byte arriving on the expiry cycle takes priority over the timeout.
  always_comb begin
    next_state = cur_state;
    store_b0   = 1'b0;
    store_b1   = 1'b0;
    decode     = 1'b0;
    reject     = 1'b0;
    timeout    = 1'b0;
    case (cur_state)
      B0: if (accept) begin
            if (rx.byte_data[3]) begin
              store_b0   = 1'b1;
              next_state = B1;
            end else begin
              reject = 1'b1;
            end
          end
      B1: if (accept) begin
            store_b1   = 1'b1;
            next_state = B2;
          end else if (tmo_hit) begin
            timeout    = 1'b1;
            next_state = B0;
          end
      B2: if (accept) begin
            decode     = 1'b1;
            next_state = B0;
          end else if (tmo_hit) begin
            timeout    = 1'b1;
            next_state = B0;
          end
      default: next_state = B0;
    endcase
  end

  // Cursor update in 12-bit signed space; PS/2 Y grows upward, screen rows grow downward.
  always_comb begin
    dx_new   = {b0_hi[0], b1};
    dy_new   = {b0_hi[1], rx.byte_data};
    nx       = $signed({2'b00, cur_x}) + $signed({{3{dx_new[8]}}, dx_new});
    ny       = $signed({3'b000, cur_y}) - $signed({{3{dy_new[8]}}, dy_new});
    nx_clamp = cur_x;
    ny_clamp = cur_y;
    if (nx < 12'sd0)       nx_clamp = 10'd0;
    else if (nx > XMAX12)  nx_clamp = XMAX12[9:0];
    else                   nx_clamp = nx[9:0];
    if (ny < 12'sd0)       ny_clamp = 9'd0;
    else if (ny > YMAX12)  ny_clamp = YMAX12[8:0];
    else                   ny_clamp = ny[8:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q      <= 1'b0;
      tcnt       <= '0;
      b0_hi      <= '0;
      b0_lo      <= '0;
      b1         <= '0;
      prev_left  <= 1'b0;
      pkt_valid  <= 1'b0;
      click      <= 1'b0;
      sync_err   <= 1'b0;
      dx         <= '0;
      dy         <= '0;
      btn_left   <= 1'b0;
      btn_right  <= 1'b0;
      btn_middle <= 1'b0;
      x_ovf      <= 1'b0;
      y_ovf      <= 1'b0;
      cur_x      <= 10'(X_INIT);
      cur_y      <= 9'(Y_INIT);
    end else begin
      rdy_q     <= rx.byte_ready;
      pkt_valid <= decode;
      click     <= decode & b0_lo[0] & ~prev_left;
      sync_err  <= reject | timeout;
      if (accept || next_state == B0) tcnt <= '0;
      else                            tcnt <= tcnt + 1'b1;
      if (store_b0) begin
        b0_hi <= rx.byte_data[7:4];
        b0_lo <= rx.byte_data[2:0];
      end
      if (store_b1) b1 <= rx.byte_data;
      if (decode) begin
        dx         <= dx_new;
        dy         <= dy_new;
        btn_left   <= b0_lo[0];
        btn_right  <= b0_lo[1];
        btn_middle <= b0_lo[2];
        x_ovf      <= b0_hi[2];
        y_ovf      <= b0_hi[3];
        prev_left  <= b0_lo[0];
        if (!b0_hi[2]) cur_x <= nx_clamp;
        if (!b0_hi[3]) cur_y <= ny_clamp;
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Scoreboard bench for ps2_mouse_packet: expected packets are queued as bytes are
// issued and a negedge monitor pops them whenever pkt_valid is seen.
module tb_ps2_mouse_packet;

  localparam int T = 40;

  logic       clk, rst;
  logic       pkt_valid, click, sync_err;
  logic [8:0] dx, dy;
  logic       btn_left, btn_right, btn_middle, x_ovf, y_ovf;
  logic [9:0] cur_x;
  logic [8:0] cur_y;
  logic [1:0] state;

  ps2_mouse_packet_if rx_if();

  typedef struct packed {
    logic [8:0] dx;
    logic [8:0] dy;
    logic [2:0] btn;
    logic [1:0] ovf;
    logic [9:0] cx;
    logic [8:0] cy;
    logic       click;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   sync_pending = 0;
  int   tests = 0;
  int   fails = 0;

  ps2_mouse_packet #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .rx(rx_if),
    .pkt_valid(pkt_valid), .dx(dx), .dy(dy),
    .btn_left(btn_left), .btn_right(btn_right), .btn_middle(btn_middle),
    .x_ovf(x_ovf), .y_ovf(y_ovf), .cur_x(cur_x), .cur_y(cur_y),
    .click(click), .sync_err(sync_err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [8:0] edx, input logic [8:0] edy,
                              input logic [2:0] ebtn, input logic [1:0] eovf,
                              input logic [9:0] ecx, input logic [8:0] ecy,
                              input logic eclick);
    exp_t e;
    e.dx = edx; e.dy = edy; e.btn = ebtn; e.ovf = eovf;
    e.cx = ecx; e.cy = ecy; e.click = eclick;
    return e;
  endfunction

  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    rx_if.byte_data  = b;
    rx_if.byte_ready = 1'b1;
    repeat (2) @(negedge clk);
    rx_if.byte_ready = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input exp_t e);
    exp_q.push_back(e);
    sendByte(b0);
    sendByte(b1);
    sendByte(b2);
    repeat (2) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every pkt_valid must match the oldest queued packet, every sync_err a pending one.
  always @(negedge clk) begin
    if (!rst) begin
      if (pkt_valid) begin
        checkOutput("pkt_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          checkOutput("dx", int'(dx), int'(mon_e.dx));
          checkOutput("dy", int'(dy), int'(mon_e.dy));
          checkOutput("buttons", int'({btn_middle, btn_right, btn_left}), int'(mon_e.btn));
          checkOutput("ovf", int'({y_ovf, x_ovf}), int'(mon_e.ovf));
          checkOutput("cur_x", int'(cur_x), int'(mon_e.cx));
          checkOutput("cur_y", int'(cur_y), int'(mon_e.cy));
          checkOutput("click", int'(click), int'(mon_e.click));
        end
      end
      if (click && !pkt_valid) checkOutput("click_with_pkt", int'(pkt_valid), 1);
      if (sync_err) begin
        checkOutput("sync_err_expected", int'(sync_pending > 0), 1);
        if (sync_pending > 0) sync_pending--;
      end
    end
  end

  initial begin
    rst = 1'b1;
    rx_if.byte_ready = 1'b0;
    rx_if.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("reset_state", int'(state), 0);
    checkOutput("reset_cur_x", int'(cur_x), 320);
    checkOutput("reset_cur_y", int'(cur_y), 240);
    checkOutput("reset_dx", int'(dx), 0);
    checkOutput("reset_pkt_valid", int'(pkt_valid), 0);
    checkOutput("reset_sync_err", int'(sync_err), 0);

    // Normal decode and click detection
    applyStimulus(8'h28, 8'h0A, 8'hF6, mk(9'h00A, 9'h1F6, 3'b000, 2'b00, 10'd330, 9'd250, 1'b0));
    applyStimulus(8'h09, 8'h00, 8'h00, mk(9'h000, 9'h000, 3'b001, 2'b00, 10'd330, 9'd250, 1'b1));
    applyStimulus(8'h09, 8'h00, 8'h00, mk(9'h000, 9'h000, 3'b001, 2'b00, 10'd330, 9'd250, 1'b0));
    applyStimulus(8'h08, 8'h00, 8'h00, mk(9'h000, 9'h000, 3'b000, 2'b00, 10'd330, 9'd250, 1'b0));
    applyStimulus(8'h09, 8'h00, 8'h00, mk(9'h000, 9'h000, 3'b001, 2'b00, 10'd330, 9'd250, 1'b1));

    // Resync on a bad first byte
    sync_pending++;
    sendByte(8'h00);
    @(negedge clk);
    checkOutput("resync_state", int'(state), 0);
    applyStimulus(8'h28, 8'h0A, 8'hF6, mk(9'h00A, 9'h1F6, 3'b000, 2'b00, 10'd340, 9'd260, 1'b0));

    // Timeout fires exactly TIMEOUT_CYCLES edges after the first byte
    sync_pending++;
    @(negedge clk);
    rx_if.byte_data  = 8'h08;
    rx_if.byte_ready = 1'b1;
    @(negedge clk);
    rx_if.byte_ready = 1'b0;
    repeat (T - 1) @(negedge clk);
    checkOutput("pre_expiry_state", int'(state), 1);
    @(negedge clk);
    checkOutput("post_expiry_state", int'(state), 0);
    checkOutput("timeout_sync_err", int'(sync_err), 1);
    repeat (2) @(negedge clk);
    applyStimulus(8'h08, 8'h00, 8'h00, mk(9'h000, 9'h000, 3'b000, 2'b00, 10'd340, 9'd260, 1'b0));

    // A byte accepted on the expiry edge wins over the timeout
    exp_q.push_back(mk(9'h005, 9'h000, 3'b000, 2'b00, 10'd345, 9'd260, 1'b0));
    @(negedge clk);
    rx_if.byte_data  = 8'h08;
    rx_if.byte_ready = 1'b1;
    @(negedge clk);
    rx_if.byte_ready = 1'b0;
    repeat (T - 1) @(negedge clk);
    rx_if.byte_data  = 8'h05;
    rx_if.byte_ready = 1'b1;
    @(negedge clk);
    checkOutput("expiry_byte_state", int'(state), 2);
    rx_if.byte_ready = 1'b0;
    sendByte(8'h00);
    repeat (2) @(negedge clk);

    // Clamping at both screen edges
    doReset();
    applyStimulus(8'h18, 8'h00, 8'h00, mk(9'h100, 9'h000, 3'b000, 2'b00, 10'd64,  9'd240, 1'b0));
    applyStimulus(8'h18, 8'h00, 8'h00, mk(9'h100, 9'h000, 3'b000, 2'b00, 10'd0,   9'd240, 1'b0));
    applyStimulus(8'h08, 8'hFF, 8'h00, mk(9'h0FF, 9'h000, 3'b000, 2'b00, 10'd255, 9'd240, 1'b0));
    applyStimulus(8'h08, 8'hFF, 8'h00, mk(9'h0FF, 9'h000, 3'b000, 2'b00, 10'd510, 9'd240, 1'b0));
    applyStimulus(8'h08, 8'hFF, 8'h00, mk(9'h0FF, 9'h000, 3'b000, 2'b00, 10'd639, 9'd240, 1'b0));
    applyStimulus(8'h08, 8'hFF, 8'h00, mk(9'h0FF, 9'h000, 3'b000, 2'b00, 10'd639, 9'd240, 1'b0));
    applyStimulus(8'h08, 8'h00, 8'hFB, mk(9'h000, 9'h0FB, 3'b000, 2'b00, 10'd639, 9'd0,   1'b0));
    applyStimulus(8'h28, 8'h00, 8'h00, mk(9'h000, 9'h100, 3'b000, 2'b00, 10'd639, 9'd256, 1'b0));
    applyStimulus(8'h28, 8'h00, 8'h00, mk(9'h000, 9'h100, 3'b000, 2'b00, 10'd639, 9'd479, 1'b0));

    // Overflow flags freeze the matching axis
    applyStimulus(8'h58, 8'h00, 8'h00, mk(9'h100, 9'h000, 3'b000, 2'b01, 10'd639, 9'd479, 1'b0));
    applyStimulus(8'h88, 8'h00, 8'h10, mk(9'h000, 9'h010, 3'b000, 2'b10, 10'd639, 9'd479, 1'b0));

    // Reset mid-packet aborts it; the next three bytes form a fresh packet
    sendByte(8'h09);
    sendByte(8'h10);
    doReset();
    checkOutput("midrst_state", int'(state), 0);
    checkOutput("midrst_cur_x", int'(cur_x), 320);
    checkOutput("midrst_cur_y", int'(cur_y), 240);
    checkOutput("midrst_dy", int'(dy), 0);
    checkOutput("midrst_y_ovf", int'(y_ovf), 0);
    applyStimulus(8'h09, 8'h01, 8'h02, mk(9'h001, 9'h002, 3'b001, 2'b00, 10'd321, 9'd238, 1'b1));

    repeat (4) @(negedge clk);
    checkOutput("packets_outstanding", exp_q.size(), 0);
    checkOutput("sync_err_outstanding", sync_pending, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_packet.md
# ps2_mouse_packet

Assembles the byte stream from the PS/2 serial receiver into standard 3-byte PS/2 mouse packets. Validates packet framing and resynchronises after lost bytes. Decodes signed X/Y movement, button state and overflow flags, and maintains a clamped 640x480 cursor position. Sits between the PS/2 byte receiver and the cursor-driven object motion and display logic.

## Interface
Parameters:
- TIMEOUT_CYCLES, 5000000, max idle cycles between bytes of one packet (100 ms at 50 MHz)
- X_MAX, 639, largest cursor X
- Y_MAX, 479, largest cursor Y
- X_INIT, 320, cursor X after reset
- Y_INIT, 240, cursor Y after reset

Ports:
- clk  in  1  system clock; one clock domain
- rst  in  1  reset; asynchronous, active-high
- byte_ready  in  1  receiver ready level; a new byte is signalled by its 0->1 transition
- byte_data  in  8  receiver byte; stable while byte_ready=1
- pkt_valid  out  1  one-cycle pulse; a decoded packet is present on the outputs
- dx  out  9  signed X movement, {b0[4], b1}
- dy  out  9  signed Y movement, {b0[5], b2}; PS/2 convention, up is positive
- btn_left / btn_right / btn_middle  out  1 each  b0[0] / b0[1] / b0[2]
- x_ovf / y_ovf  out  1 each  b0[6] / b0[7]
- cur_x  out  10  cursor column
- cur_y  out  9  cursor row
- click  out  1  one-cycle pulse on a left-button 0->1 transition between packets
- sync_err  out  1  one-cycle pulse on a rejected first byte or an inter-byte timeout
- state  out  2  debug view of the FSM: 0=B0, 1=B1, 2=B2

## Operation
- Edge detect: byte_ready is registered into rdy_q. A byte is accepted on an edge where byte_ready=1 and rdy_q=0. byte_data is sampled on that same edge.
- FSM states: B0 (expect byte 0), B1, B2.
  - B0: an accepted byte with bit3=1 is stored as b0 and the FSM moves to B1. An accepted byte with bit3=0 pulses sync_err and the FSM stays in B0.
  - B1: an accepted byte is stored as b1 and the FSM moves to B2.
  - B2: an accepted byte is b2. The FSM decodes the packet and returns to B0.
- Timeout counter:
  - Cleared on every accepted byte and held at 0 while in B0.
  - In B1 or B2 it increments each cycle. On reaching TIMEOUT_CYCLES-1, the FSM goes to B0 and sync_err pulses. The partial packet is discarded and no outputs change.
  - If a byte is accepted on the same cycle the timeout would fire, the byte wins: it is accepted and there is no sync_err.
- Decode, on the edge accepting b2:
  - Register dx, dy, all buttons and both overflow flags.
  - click = b0[0] & ~prev_left. prev_left is then updated to b0[0].
- Position arithmetic: 12-bit signed. nx = cur_x + dx; ny = cur_y - dy.
  - Each result is clamped to [0, X_MAX] and [0, Y_MAX] respectively.
  - If x_ovf=1, the X position is not changed (dx is still reported). y_ovf applies the same rule to Y.
- Reset values:
  - pkt_valid, click, sync_err = 0.
  - dx, dy, all buttons, both overflow flags, prev_left = 0.
  - cur_x = X_INIT, cur_y = Y_INIT.
  - state = B0, timeout counter = 0, rdy_q = 0.
- Reset asserted mid-packet aborts the packet immediately. No pulse is produced.

## Timing
- Byte acceptance latency: one edge after byte_ready rises, because the 0->1 transition is detected against rdy_q.
- Packet outputs: dx, dy, buttons, overflow flags, cur_x and cur_y all update on the edge that accepts b2. pkt_valid (and click, if applicable) is high for exactly the following cycle.
- sync_err is high for exactly one cycle after the rejecting or timeout edge.
- A byte_ready level held high produces exactly one acceptance. Back-to-back bytes are accepted whenever byte_ready drops for at least one cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Normal decode: after reset, send 0x28, 0x0A, 0xF6 -> one pkt_valid pulse; dx=+10, dy=-10, cur_x=330, cur_y=250, all buttons 0, sync_err never asserted.
- Click detect: send 0x09,0x00,0x00 -> btn_left=1 and click pulses with pkt_valid. Send 0x09,0x00,0x00 again -> no click. Send 0x08,0x00,0x00 then 0x09,0x00,0x00 -> click pulses again.
- Resync: send 0x00 -> sync_err pulse, state stays 0. Then send 0x28, 0x0A, 0xF6 -> decodes as in the normal-decode case.
- Timeout: send 0x08, then idle for TIMEOUT_CYCLES -> sync_err pulses, state returns to 0, no pkt_valid. A following full packet decodes correctly. Also, a byte arriving exactly at expiry is accepted with no sync_err.
- Clamping: from reset, send 0x18,0x00,0x00 twice -> cur_x = 64, then 0. Send 0x08,0xFF,0x00 repeatedly -> cur_x saturates at 639. Send 0x08,0x00,0xFB -> cur_y = max(prev-251, 0).
- Overflow and reset: send 0x48,0x7F,0x00 -> dx=127, x_ovf=1, cur_x unchanged. Assert rst after byte 1 of a packet -> all outputs return to reset values, and the next 3 bytes form a fresh packet.
